// File: rtl/apb_master_seq_pkg.sv
// Shared definitions for the APB requester: FSM encoding, strobe-width derivation
// and the matmul slave register offsets used by software and benches.
package apb_master_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    localparam logic [4:0] REG_CONTROL   = 5'h00;
    localparam logic [4:0] REG_OPERAND_A = 5'h04;
    localparam logic [4:0] REG_OPERAND_B = 5'h08;
    localparam logic [4:0] REG_FLAGS     = 5'h0C;
    localparam logic [4:0] REG_SP        = 5'h10;

    // One strobe per matrix element carried on the bus.
    function automatic int strb_width(input int bus_w, input int data_w);
        return bus_w / data_w;
    endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO with full/empty/count; DEPTH must be a power of two
// so the pointers wrap naturally.
module apb_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage has no reset; entries are only read after being written, so clearing them costs logic for nothing.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/apb_master_seq.sv
// APB requester: queues commands, runs SETUP/ACCESS with wait-state and timeout
// handling, and returns exactly one registered response per command.
module apb_master_seq
    import apb_master_seq_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int BUS_WIDTH  = 64,
    parameter  int ADDR_WIDTH = 32,
    parameter  int FIFO_DEPTH = 4,
    parameter  int TIMEOUT    = 16,
    localparam int STRB_WIDTH = strb_width(BUS_WIDTH, DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
    input  logic [STRB_WIDTH-1:0] cmd_strb_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [BUS_WIDTH-1:0]  pwdata_o,
    output logic [STRB_WIDTH-1:0] pstrb_o,
    input  logic [BUS_WIDTH-1:0]  prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);
    localparam int CMD_W  = 1 + ADDR_WIDTH + BUS_WIDTH + STRB_WIDTH;
    localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e state_q, state_d;

    logic [CMD_W-1:0]      fifo_rdata;
    logic                  fifo_full, fifo_empty, fifo_pop;
    logic [FCNT_W-1:0]     fifo_count;
    logic                  head_write;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [BUS_WIDTH-1:0]  head_wdata;
    logic [STRB_WIDTH-1:0] head_strb;

    logic                  psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [BUS_WIDTH-1:0]  pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
    logic                  rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic [BUS_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  launch, timeout_hit, apb_clear;

    apb_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (cmd_valid_i),
        .data_i  ({cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign {head_write, head_addr, head_wdata, head_strb} = fifo_rdata;
    assign cmd_ready_o = ~fifo_full;

    // Only launch when the response slot will be free by the time this transfer completes.
    assign launch      = ~fifo_empty & (~rsp_valid_q | rsp_ready_i);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST) && !pready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:   state_d = launch ? ST_SETUP : ST_IDLE;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: state_d = (pready_i || timeout_hit) ? ST_IDLE : ST_ACCESS;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: every comb output gets a default first, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = rsp_valid_q & ~rsp_ready_i;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;
        fifo_pop      = 1'b0;
        apb_clear     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = head_write;
                    paddr_d   = head_addr;
                    pwdata_d  = head_write ? head_wdata : '0;
                    pstrb_d   = head_write ? head_strb  : '0;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ST_ACCESS: begin
                if (pready_i) begin
                    fifo_pop      = 1'b1;
                    apb_clear     = 1'b1;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : prdata_i;
                    rsp_err_d     = pslverr_i;
                    rsp_timeout_d = 1'b0;
                end else if (timeout_hit) begin
                    fifo_pop      = 1'b1;
                    apb_clear     = 1'b1;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: apb_clear = 1'b1;
        endcase
        if (apb_clear) begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            pwrite_d  = 1'b0;
            paddr_d   = '0;
            pwdata_d  = '0;
            pstrb_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    assign psel_o        = psel_q;
    assign penable_o     = penable_q;
    assign pwrite_o      = pwrite_q;
    assign paddr_o       = paddr_q;
    assign pwdata_o      = pwdata_q;
    assign pstrb_o       = pstrb_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;

    a_fifo_count: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (fifo_count <= FCNT_W'(FIFO_DEPTH)) && (fifo_full == (fifo_count == FCNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_apb_master_seq.sv
// Randomised bench: commands are planned together with the slave's behaviour, the
// expected response is derived from that plan and checked by an independent monitor.
module tb_apb_master_seq;
    import apb_master_seq_pkg::*;

    localparam int DW = 32, BW = 64, AW = 32, SW = BW / DW, DEPTH = 4, TO = 16;

    typedef struct {
        bit          write;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
        logic [SW-1:0] strb;
        int          waits;
        bit          perr;
        logic [BW-1:0] rdata;
    } plan_t;

    typedef struct {
        logic [BW-1:0] rdata;
        bit          err;
        bit          tmo;
    } rsp_t;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          cmd_valid_i = 1'b0, cmd_write_i = 1'b0;
    logic [AW-1:0] cmd_addr_i = '0;
    logic [BW-1:0] cmd_wdata_i = '0;
    logic [SW-1:0] cmd_strb_i = '0;
    logic          cmd_ready_o, rsp_valid_o, rsp_ready_i = 1'b0, rsp_err_o, rsp_timeout_o;
    logic [BW-1:0] rsp_rdata_o, pwdata_o, prdata_i = '0;
    logic          psel_o, penable_o, pwrite_o, pready_i = 1'b0, pslverr_i = 1'b0;
    logic [AW-1:0] paddr_o;
    logic [SW-1:0] pstrb_o;

    plan_t plan_q[$];
    rsp_t  exp_q[$];
    int    checks = 0, errors = 0;
    int    rsp_mode = 2;  // 0 random ready, 1 hold off, 2 always ready

    apb_master_seq #(
        .DATA_WIDTH (DW), .BUS_WIDTH (BW), .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH), .TIMEOUT (TO)
    ) dut (
        .clk_i (clk_i), .rst_ni (rst_ni),
        .cmd_valid_i (cmd_valid_i), .cmd_ready_o (cmd_ready_o), .cmd_write_i (cmd_write_i),
        .cmd_addr_i (cmd_addr_i), .cmd_wdata_i (cmd_wdata_i), .cmd_strb_i (cmd_strb_i),
        .rsp_valid_o (rsp_valid_o), .rsp_ready_i (rsp_ready_i), .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o (rsp_err_o), .rsp_timeout_o (rsp_timeout_o),
        .psel_o (psel_o), .penable_o (penable_o), .pwrite_o (pwrite_o),
        .paddr_o (paddr_o), .pwdata_o (pwdata_o), .pstrb_o (pstrb_o),
        .prdata_i (prdata_i), .pready_i (pready_i), .pslverr_i (pslverr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: what the requester must report for a given command and slave behaviour.
    function automatic rsp_t model(input plan_t p);
        rsp_t r;
        if (TO != 0 && p.waits >= TO) begin
            r.rdata = '0; r.err = 1'b1; r.tmo = 1'b1;
        end else begin
            r.rdata = p.write ? '0 : p.rdata; r.err = p.perr; r.tmo = 1'b0;
        end
        return r;
    endfunction

    function automatic plan_t mk(input bit w, input logic [AW-1:0] a, input logic [BW-1:0] d,
                                 input logic [SW-1:0] s, input int waits, input bit perr,
                                 input logic [BW-1:0] rd);
        plan_t p;
        p.write = w; p.addr = a; p.wdata = d; p.strb = s;
        p.waits = waits; p.perr = perr; p.rdata = rd;
        return p;
    endfunction

    function automatic plan_t rand_plan();
        logic [4:0] offs [5];
        int sel, waits;
        offs = '{REG_CONTROL, REG_OPERAND_A, REG_OPERAND_B, REG_FLAGS, REG_SP};
        sel = int'($urandom_range(0, 5));
        if ($urandom_range(0, 7) == 0)
            waits = ($urandom_range(0, 1) == 1) ? TO - 1 : TO + int'($urandom_range(0, 6));
        else
            waits = int'($urandom_range(0, 3));
        return mk(1'($urandom_range(0, 1)),
                  (sel < 5) ? AW'(offs[sel]) : AW'($urandom),
                  {$urandom, $urandom}, SW'($urandom_range(0, 3)), waits,
                  ($urandom_range(0, 3) == 0), {$urandom, $urandom});
    endfunction

    task automatic push_cmd(input plan_t p);
        int n = 0;
        @(negedge clk_i);
        cmd_valid_i = 1'b1; cmd_write_i = p.write; cmd_addr_i = p.addr;
        cmd_wdata_i = p.wdata; cmd_strb_i = p.strb;
        while (!cmd_ready_o && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        check("cmd_accept_timely", 64'(n < 500), 64'd1);
        if (n < 500) begin
            @(posedge clk_i);
            plan_q.push_back(p);
            exp_q.push_back(model(p));
        end
        #1 cmd_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || plan_q.size() != 0) && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        check("drain_timely", 64'(n < 3000), 64'd1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_psel"}, 64'(psel_o), 64'd0);
        check({tag, "_penable"}, 64'(penable_o), 64'd0);
        check({tag, "_pwrite"}, 64'(pwrite_o), 64'd0);
        check({tag, "_paddr"}, 64'(paddr_o), 64'd0);
        check({tag, "_pwdata"}, pwdata_o, 64'd0);
        check({tag, "_pstrb"}, 64'(pstrb_o), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata_o, 64'd0);
        check({tag, "_rsp_err"}, 64'(rsp_err_o), 64'd0);
        check({tag, "_rsp_timeout"}, 64'(rsp_timeout_o), 64'd0);
        check({tag, "_cmd_ready"}, 64'(cmd_ready_o), 64'd1);
    endtask

    task automatic check_apb(input string tag, input plan_t p);
        check({tag, "_pwrite"}, 64'(pwrite_o), 64'(p.write));
        check({tag, "_paddr"}, 64'(paddr_o), 64'(p.addr));
        check({tag, "_pwdata"}, pwdata_o, p.write ? p.wdata : 64'd0);
        check({tag, "_pstrb"}, 64'(pstrb_o), p.write ? 64'(p.strb) : 64'd0);
    endtask

    // APB slave: follows the plan of the command that reaches SETUP, checks the
    // transfer shape and drives junk on pready/pslverr outside the completing beat.
    initial begin
        plan_t cur;
        bit    active = 1'b0, pend = 1'b0;
        int    acc = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                active = 1'b0; pend = 1'b0; pready_i = 1'b0; pslverr_i = 1'b0;
            end else begin
                if (pend) begin
                    check("rsp_valid_after_done", 64'(rsp_valid_o), 64'd1);
                    check("psel_low_after_done", 64'(psel_o), 64'd0);
                    pend = 1'b0;
                end
                if (psel_o && !penable_o) begin
                    check("setup_has_plan", 64'(plan_q.size() != 0), 64'd1);
                    if (plan_q.size() != 0) begin
                        cur = plan_q.pop_front();
                        check_apb("setup", cur);
                        active = 1'b1;
                        acc = 0;
                    end
                    pready_i = 1'($urandom); pslverr_i = 1'($urandom);
                    prdata_i = {$urandom, $urandom};
                end else if (psel_o && penable_o) begin
                    check("access_follows_setup", 64'(active), 64'd1);
                    if (active) begin
                        check_apb("access", cur);
                        pready_i  = (acc == cur.waits);
                        pslverr_i = pready_i ? cur.perr : 1'($urandom);
                        prdata_i  = pready_i ? cur.rdata : {$urandom, $urandom};
                        acc++;
                        if (pready_i) begin
                            active = 1'b0;
                            pend = 1'b1;
                        end
                    end
                end else begin
                    if (active) begin
                        check("abort_expected", 64'(cur.waits >= TO), 64'd1);
                        check("abort_access_cycles", 64'(acc), 64'(TO));
                        check("abort_rsp_valid", 64'(rsp_valid_o), 64'd1);
                        active = 1'b0;
                    end
                    pready_i = 1'($urandom); pslverr_i = 1'($urandom);
                    prdata_i = {$urandom, $urandom};
                end
            end
        end
    end

    always @(negedge clk_i)
        rsp_ready_i = (rsp_mode == 0) ? ($urandom_range(0, 2) != 0) : (rsp_mode == 2);

    // Monitor: a handshake is visible from just after the falling edge until the next rise.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk_i);
            #1;
            if (rst_ni && rsp_valid_o && rsp_ready_i) begin
                check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", rsp_rdata_o, e.rdata);
                    check("rsp_err", 64'(rsp_err_o), 64'(e.err));
                    check("rsp_timeout", 64'(rsp_timeout_o), 64'(e.tmo));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, seen;
        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        #1 check_quiet("reset");
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;

        push_cmd(mk(1'b1, AW'(REG_OPERAND_A), 64'h1122334455667788, 2'b11, 0, 1'b0, {$urandom, $urandom}));
        push_cmd(mk(1'b0, AW'(REG_OPERAND_B), {$urandom, $urandom}, 2'b01, 3, 1'b0, 64'hDEADBEEF_CAFEF00D));
        push_cmd(mk(1'b1, AW'(REG_FLAGS), {$urandom, $urandom}, 2'b10, 1, 1'b1, '0));
        push_cmd(mk(1'b0, AW'(REG_SP), {$urandom, $urandom}, 2'b11, 1000, 1'b0, {$urandom, $urandom}));
        drain();

        rsp_mode = 0;
        repeat (60) push_cmd(rand_plan());
        drain();

        rsp_mode = 1;
        for (int i = 0; i < 5; i++)
            push_cmd(mk(1'b1, AW'(32'h100 + 4 * i), {$urandom, $urandom}, 2'b11, 0, 1'b0, '0));
        repeat (8) @(negedge clk_i);
        #1;
        check("bp_cmd_ready", 64'(cmd_ready_o), 64'd0);
        check("bp_no_second_setup", 64'(psel_o), 64'd0);
        check("bp_rsp_held", 64'(rsp_valid_o), 64'd1);
        check("bp_nothing_consumed", 64'(exp_q.size()), 64'd5);
        rsp_mode = 0;
        drain();

        rsp_mode = 2;
        push_cmd(mk(1'b0, AW'(REG_CONTROL), '0, '0, 10, 1'b0, {$urandom, $urandom}));
        push_cmd(rand_plan());
        push_cmd(rand_plan());
        n = 0;
        while (!(psel_o && penable_o) && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check("reach_access_before_reset", 64'(psel_o && penable_o), 64'd1);
        #2 rst_ni = 1'b0;
        #1 check_quiet("mid_reset");
        plan_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk_i);
            #1 if (psel_o || rsp_valid_o) seen++;
        end
        check("no_activity_after_reset", 64'(seen), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
